// File: rtl/mem_port_arbiter.sv
// Arbiter for the single unified memory port shared by instruction fetch and data access.
// Fetch starvation is bounded by MAX_STARVE; unacknowledged accesses abort after TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_read
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;

    logic busy;
    logic expired;
    logic done;
    logic starved;
    logic grant_i;
    logic grant_d;

    assign busy    = (state != IDLE);
    // An ack on the last allowed cycle wins over the abort.
    assign expired = busy && !mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));
    assign done    = busy && (mem_ack || expired);

    assign starved = (starve_cnt == SW'(MAX_STARVE));
    assign grant_i = (state == IDLE) && i_req && (!d_req || starved);
    assign grant_d = (state == IDLE) && d_req && !grant_i;

    assign i_ready    = (state == BUSY_I) && done;
    assign d_ready    = (state == BUSY_D) && done;
    assign bus_err    = expired;
    assign i_rdata    = ((state == BUSY_I) && mem_ack) ? mem_rdata : 32'h0;
    assign d_rdata    = ((state == BUSY_D) && mem_ack) ? mem_rdata : 32'h0;
    assign stall_read = (i_req && !i_ready) || (d_req && !d_ready);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'h0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (grant_i) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= 32'h0;
                        mem_wstrb <= 4'h0;
                    end else if (grant_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : 4'h0;
                    end
                end
                default: begin
                    if (done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
            endcase

            // Counts data grants that overtook a waiting fetch.
            if (!i_req || grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d && !starved) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule
